// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its input-side helpers.
// Holds the request FSM state type and the default timing constants for the 10 MHz domain.
// No logic. Importers derive their default cycle counts from these constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2
  } req_state_t;

  localparam int CLK_HZ      = 10000000;
  localparam int DEBOUNCE_MS = 10;
  localparam int HOLD_MS     = 2000;

  // Cycle counts that correspond to the millisecond constants above.
  localparam int DEBOUNCE_CYCLES_DFLT = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int HOLD_CYCLES_DFLT     = (CLK_HZ / 1000) * HOLD_MS;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus debounce counter for a board switch or button.
// Latency: a level change shows on level_o after edge DEBOUNCE_CYCLES+1, counted from the edge that first samples it.
// Backpressure: none. This block free-runs every cycle.
//
// Ports: clk, reset (sync, active high), raw_i (asynchronous level),
//        level_o (debounced level), rise_o (one-cycle pulse on a debounced rising edge).
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count measures how long the synchronized input has disagreed with the accepted level.
  // Any agreement restarts the count, so a shorter glitch never gets through.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      // The pulse is registered together with the level, so it covers the first high cycle.
      rise_q  <= level_d & ~level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sensor_request_conditioner.sv
// Turns the raw secondary-road car sensor into a latched car request for the traffic light controller.
// Latency: car_request rises after edge DEBOUNCE_CYCLES+2, or DEBOUNCE_CYCLES+HOLD_CYCLES+2 with SENSOR_HOLD_EN. It falls one edge after request_ack.
// Backpressure: the request stays latched until request_ack. An ack outside PENDING is ignored.
//
// Ports: clk, reset (sync, active high), sensor_raw (async switch), request_ack (one-cycle grant pulse),
//        sensor_level (debounced), rise_pulse (debounced rising edge), car_request (latched request).
// Build option: define SENSOR_HOLD_EN to require HOLD_CYCLES of continuous presence before a request.
// Without it, a debounced high raises the request directly.
module sensor_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_raw,
  input  logic request_ack,
  output logic sensor_level,
  output logic rise_pulse,
  output logic car_request
);

  logic       level;
  req_state_t state_q;
  logic       car_request_q;

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (sensor_raw),
    .level_o(level),
    .rise_o (rise_pulse)
  );

`ifdef SENSOR_HOLD_EN
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      car_request_q <= 1'b0;
      hold_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (level) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (!level) begin
            state_q <= IDLE;
            hold_q  <= '0;
          end else if (hold_q == HOLD_LAST) begin
            state_q       <= PENDING;
            car_request_q <= 1'b1;
            hold_q        <= '0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        PENDING: begin
          // The request stays latched even if the car leaves. Only the grant clears it.
          if (request_ack) begin
            state_q       <= IDLE;
            car_request_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          car_request_q <= 1'b0;
          hold_q        <= '0;
        end
      endcase
    end
  end
`else
  // The hold time has no effect in this build.
  localparam int hold_cycles_unused = HOLD_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      car_request_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level) begin
            state_q       <= PENDING;
            car_request_q <= 1'b1;
          end
        end
        PENDING: begin
          // The request stays latched even if the car leaves. Only the grant clears it.
          if (request_ack) begin
            state_q       <= IDLE;
            car_request_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          car_request_q <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign sensor_level = level;
  assign car_request  = car_request_q;

endmodule

// File: tb/tb_sensor_request_conditioner.sv
module tb_sensor_request_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 8;
`ifdef SENSOR_HOLD_EN
  localparam int THRESH  = HOLD + 1;
  localparam bit HOLD_ON = 1'b1;
`else
  localparam int THRESH  = 1;
  localparam bit HOLD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor_raw = 1'b0;
  logic request_ack = 1'b0;
  logic sensor_level, rise_pulse, car_request;

  int passes = 0;
  int checks = 0;

  sensor_request_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_raw  (sensor_raw),
    .request_ack (request_ack),
    .sensor_level(sensor_level),
    .rise_pulse  (rise_pulse),
    .car_request (car_request)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model.
  // The level flips once the last DB synchronized samples all disagree with it.
  // A request is raised after THRESH consecutive edges that see the level high while no request is held.
  logic [DB+1:0] m_hist  = '0;
  logic          m_level = 1'b0;
  logic          m_rise  = 1'b0;
  logic          m_req   = 1'b0;
  int            m_run   = 0;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hist  = '0;
      m_level = 1'b0;
      m_rise  = 1'b0;
      m_req   = 1'b0;
      m_run   = 0;
    end else begin
      logic prev;
      logic all_diff;
      prev     = m_level;
      m_hist   = {m_hist[DB:0], sensor_raw};
      all_diff = 1'b1;
      // m_hist[k] is the raw value sampled k edges ago. Samples 2 through DB+1 have passed the synchronizer.
      for (int k = 2; k <= DB + 1; k++) if (m_hist[k] == prev) all_diff = 1'b0;
      if (all_diff) m_level = ~prev;
      m_rise = m_level & ~prev;
      if (m_req) begin
        if (request_ack) m_req = 1'b0;
        m_run = 0;
      end else if (prev) begin
        m_run++;
        if (m_run == THRESH) begin
          m_req = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("cmp_level", sensor_level, m_level);
      check("cmp_rise", rise_pulse, m_rise);
      check("cmp_req", car_request, m_req);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    bit seen;

    // Hold reset with the sensor high. All outputs must stay low.
    reset = 1'b1;
    sensor_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_level", sensor_level, 1'b0);
      check("rst_rise", rise_pulse, 1'b0);
      check("rst_req", car_request, 1'b0);
    end
    reset = 1'b0;
    tick(5);  // edges 0..4
    check("deb_edge4_level", sensor_level, 1'b0);
    tick(1);  // edge 5
    check("deb_edge5_level", sensor_level, 1'b1);
    check("deb_edge5_rise", rise_pulse, 1'b1);
    tick(1);  // edge 6
    check("edge6_rise_low", rise_pulse, 1'b0);
    check("edge6_req", car_request, !HOLD_ON);
    tick(THRESH - 1);
    check("req_raised", car_request, 1'b1);

    // Handshake: the ack clears the request, and a sensor that is still high re-requests.
    request_ack = 1'b1;
    tick(1);
    request_ack = 1'b0;
    check("ack_clears", car_request, 1'b0);
    tick(THRESH);
    check("rerequest", car_request, 1'b1);

    // The request stays latched after the car leaves.
    sensor_raw = 1'b0;
    tick(DB + 3);
    check("latch_level_low", sensor_level, 1'b0);
    check("latch_req_held", car_request, 1'b1);
    request_ack = 1'b1;
    tick(1);
    request_ack = 1'b0;
    check("latch_ack_clears", car_request, 1'b0);
    tick(3);
    // A stray ack in IDLE must change nothing.
    request_ack = 1'b1;
    tick(1);
    request_ack = 1'b0;
    check("stray_ack_req", car_request, 1'b0);
    tick(2);
    check("stray_ack_after", car_request, 1'b0);

    // A glitch shorter than the debounce window is rejected.
    seen = 1'b0;
    sensor_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (sensor_level | rise_pulse | car_request) seen = 1'b1;
    end
    sensor_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (sensor_level | rise_pulse | car_request) seen = 1'b1;
    end
    check("glitch_rejected", seen, 1'b0);

    // Short presence: the debounced level is high for 6 cycles. This is filtered only when the hold check is built in.
    sensor_raw = 1'b1;
    tick(6);
    check("short_level_up", sensor_level, 1'b1);
    sensor_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (car_request) seen = 1'b1;
    end
    check("short_presence_req", seen, !HOLD_ON);
    request_ack = 1'b1;
    tick(1);
    request_ack = 1'b0;
    tick(2);
    check("cleanup_req", car_request, 1'b0);

    // Reset while PENDING discards everything, including the partial debounce history.
    sensor_raw = 1'b1;
    tick(DB + THRESH + 2);
    check("pre_reset_req", car_request, 1'b1);
    reset = 1'b1;
    tick(1);
    check("midrst_req", car_request, 1'b0);
    check("midrst_level", sensor_level, 1'b0);
    check("midrst_rise", rise_pulse, 1'b0);
    reset = 1'b0;
    tick(DB + 1);
    check("post_rst_edge4_level", sensor_level, 1'b0);
    tick(1);
    check("post_rst_edge5_level", sensor_level, 1'b1);
    check("post_rst_edge5_rise", rise_pulse, 1'b1);
    sensor_raw = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
